// File: rtl/sdhci_rsp_receiver.sv
// SD command-response receiver: waits for the start bit on CMD, shifts in a 48- or 136-bit
// response, and checks CRC7, end bit and command index.
module sdhci_rsp_receiver #(
  parameter int unsigned TimeoutStrobes = 64,
  parameter int unsigned CntWidth       = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         sd_clk_en_i,
  input  logic         sd_cmd_i,
  input  logic         start_i,
  input  logic         long_rsp_i,
  input  logic         check_crc_i,
  input  logic         check_index_i,
  input  logic [5:0]   cmd_index_i,
  input  logic         abort_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [119:0] rsp_o,
  output logic         timeout_err_o,
  output logic         crc_err_o,
  output logic         end_bit_err_o,
  output logic         index_err_o
);

  typedef enum logic [1:0] {StIdle, StWaitStart, StReceive, StDone} state_e;

  state_e                state_q, state_d;
  logic [CntWidth-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CntWidth-1:0]   to_cnt_q, to_cnt_d;
  logic [6:0]            crc_q, crc_d;
  logic [6:0]            rx_crc_q, rx_crc_d;
  logic [5:0]            idx_q, idx_d;
  logic [119:0]          rsp_q, rsp_d;
  logic                  timeout_q, timeout_d;
  logic                  crc_err_q, crc_err_d;
  logic                  end_err_q, end_err_d;
  logic                  idx_err_q, idx_err_d;
  logic                  long_q, long_d;
  logic                  chk_crc_q, chk_crc_d;
  logic                  chk_idx_q, chk_idx_d;
  logic [5:0]            exp_idx_q, exp_idx_d;

  // Frame landmarks, counted from the start bit as bit 0.
  logic [CntWidth-1:0]   last_bit;
  logic [CntWidth-1:0]   crc_hi;
  logic [CntWidth-1:0]   rx_crc_lo;
  logic [CntWidth-1:0]   rx_crc_hi;
  logic                  in_crc;
  logic                  in_rx_crc;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
    logic fb;
    fb = crc[6] ^ b;
    return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  assign last_bit  = long_q ? CntWidth'(135) : CntWidth'(47);
  assign crc_hi    = long_q ? CntWidth'(127) : CntWidth'(39);
  assign rx_crc_lo = long_q ? CntWidth'(128) : CntWidth'(40);
  assign rx_crc_hi = long_q ? CntWidth'(134) : CntWidth'(46);

  // Long frames exclude the tx bit and reserved ones from the CRC.
  assign in_crc    = (bit_cnt_q <= crc_hi) &&
                     (long_q ? (bit_cnt_q >= CntWidth'(8)) : (bit_cnt_q >= CntWidth'(1)));
  assign in_rx_crc = (bit_cnt_q >= rx_crc_lo) && (bit_cnt_q <= rx_crc_hi);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    to_cnt_d  = to_cnt_q;
    crc_d     = crc_q;
    rx_crc_d  = rx_crc_q;
    idx_d     = idx_q;
    rsp_d     = rsp_q;
    timeout_d = timeout_q;
    crc_err_d = crc_err_q;
    end_err_d = end_err_q;
    idx_err_d = idx_err_q;
    long_d    = long_q;
    chk_crc_d = chk_crc_q;
    chk_idx_d = chk_idx_q;
    exp_idx_d = exp_idx_q;

    if (abort_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            long_d    = long_rsp_i;
            chk_crc_d = check_crc_i;
            chk_idx_d = check_index_i;
            exp_idx_d = cmd_index_i;
            rsp_d     = '0;
            timeout_d = 1'b0;
            crc_err_d = 1'b0;
            end_err_d = 1'b0;
            idx_err_d = 1'b0;
            bit_cnt_d = '0;
            to_cnt_d  = '0;
            crc_d     = '0;
            rx_crc_d  = '0;
            idx_d     = '0;
            state_d   = StWaitStart;
          end
        end
        StWaitStart: begin
          if (sd_clk_en_i) begin
            if (!sd_cmd_i) begin
              bit_cnt_d = CntWidth'(1);
              crc_d     = crc7_step(7'h00, 1'b0);
              state_d   = StReceive;
            end else begin
              to_cnt_d = to_cnt_q + 1'b1;
              if (to_cnt_d == CntWidth'(TimeoutStrobes)) begin
                timeout_d = 1'b1;
                state_d   = StDone;
              end
            end
          end
        end
        StReceive: begin
          if (sd_clk_en_i) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (in_crc) begin
              crc_d = crc7_step(crc_q, sd_cmd_i);
            end
            if (long_q) begin
              if (bit_cnt_q >= CntWidth'(8) && bit_cnt_q <= CntWidth'(127)) begin
                rsp_d = {rsp_q[118:0], sd_cmd_i};
              end
            end else begin
              if (bit_cnt_q >= CntWidth'(2) && bit_cnt_q <= CntWidth'(7)) begin
                idx_d = {idx_q[4:0], sd_cmd_i};
              end
              if (bit_cnt_q >= CntWidth'(8) && bit_cnt_q <= CntWidth'(39)) begin
                rsp_d[31:0] = {rsp_q[30:0], sd_cmd_i};
              end
            end
            if (in_rx_crc) begin
              rx_crc_d = {rx_crc_q[5:0], sd_cmd_i};
            end
            if (bit_cnt_q == last_bit) begin
              end_err_d = !sd_cmd_i;
              crc_err_d = chk_crc_q && (crc_q != rx_crc_q);
              idx_err_d = chk_idx_q && !long_q && (idx_q != exp_idx_q);
              state_d   = StDone;
            end
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      to_cnt_q  <= '0;
      crc_q     <= '0;
      rx_crc_q  <= '0;
      idx_q     <= '0;
      rsp_q     <= '0;
      timeout_q <= 1'b0;
      crc_err_q <= 1'b0;
      end_err_q <= 1'b0;
      idx_err_q <= 1'b0;
      long_q    <= 1'b0;
      chk_crc_q <= 1'b0;
      chk_idx_q <= 1'b0;
      exp_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      to_cnt_q  <= to_cnt_d;
      crc_q     <= crc_d;
      rx_crc_q  <= rx_crc_d;
      idx_q     <= idx_d;
      rsp_q     <= rsp_d;
      timeout_q <= timeout_d;
      crc_err_q <= crc_err_d;
      end_err_q <= end_err_d;
      idx_err_q <= idx_err_d;
      long_q    <= long_d;
      chk_crc_q <= chk_crc_d;
      chk_idx_q <= chk_idx_d;
      exp_idx_q <= exp_idx_d;
    end
  end

  assign busy_o        = (state_q == StWaitStart) || (state_q == StReceive);
  assign done_o        = (state_q == StDone);
  assign rsp_o         = rsp_q;
  assign timeout_err_o = timeout_q;
  assign crc_err_o     = crc_err_q;
  assign end_bit_err_o = end_err_q;
  assign index_err_o   = idx_err_q;

endmodule

// File: tb/tb_sdhci_rsp_receiver.sv
// Scoreboard bench for sdhci_rsp_receiver: expected results queued per frame, checked on done_o.
module tb_sdhci_rsp_receiver;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         sd_clk_en_i = 1'b0;
  logic         sd_cmd_i = 1'b1;
  logic         start_i = 1'b0;
  logic         long_rsp_i = 1'b0;
  logic         check_crc_i = 1'b0;
  logic         check_index_i = 1'b0;
  logic [5:0]   cmd_index_i = '0;
  logic         abort_i = 1'b0;
  logic         busy_o;
  logic         done_o;
  logic [119:0] rsp_o;
  logic         timeout_err_o;
  logic         crc_err_o;
  logic         end_bit_err_o;
  logic         index_err_o;

  sdhci_rsp_receiver #(
    .TimeoutStrobes(64),
    .CntWidth      (8)
  ) u_dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .sd_clk_en_i  (sd_clk_en_i),
    .sd_cmd_i     (sd_cmd_i),
    .start_i      (start_i),
    .long_rsp_i   (long_rsp_i),
    .check_crc_i  (check_crc_i),
    .check_index_i(check_index_i),
    .cmd_index_i  (cmd_index_i),
    .abort_i      (abort_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .rsp_o        (rsp_o),
    .timeout_err_o(timeout_err_o),
    .crc_err_o    (crc_err_o),
    .end_bit_err_o(end_bit_err_o),
    .index_err_o  (index_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [119:0] rsp;
    logic         to;
    logic         crc;
    logic         endb;
    logic         idx;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   strobe_cyc = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (!rst_i && done_o) begin
      check("sb_nonempty", 128'(sb.size() != 0), 128'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("rsp", 128'(rsp_o), 128'(e.rsp));
        check("timeout_err", 128'(timeout_err_o), 128'(e.to));
        check("crc_err", 128'(crc_err_o), 128'(e.crc));
        check("end_bit_err", 128'(end_bit_err_o), 128'(e.endb));
        check("index_err", 128'(index_err_o), 128'(e.idx));
        check("done_latency", 128'(cyc), 128'(strobe_cyc));
        check("busy_at_done", 128'(busy_o), 128'd0);
      end
    end
  end

  function automatic logic [6:0] crc7(input logic [135:0] v, input int hi, input int lo);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = hi; i >= lo; i--) begin
      fb = c[6] ^ v[i];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [135:0] short_frame(input logic [5:0] idx, input logic [31:0] st);
    logic [135:0] f;
    f        = '0;
    f[47:40] = {2'b00, idx};
    f[39:8]  = st;
    f[7:1]   = crc7(f, 47, 8);
    f[0]     = 1'b1;
    return f;
  endfunction

  function automatic logic [135:0] long_frame(input logic [119:0] pl);
    logic [135:0] f;
    f          = '0;
    f[135:128] = 8'h3F;
    f[127:8]   = pl;
    f[7:1]     = crc7(f, 127, 8);
    f[0]       = 1'b1;
    return f;
  endfunction

  // Tasks enter and leave at 1 time unit after a rising edge.
  task automatic send_bit(input logic b);
    sd_cmd_i    = b;
    sd_clk_en_i = 1'b1;
    @(posedge clk_i);
    #1;
    strobe_cyc  = cyc;
    sd_clk_en_i = 1'b0;
    sd_cmd_i    = 1'b1;
    repeat ($urandom_range(2)) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic send_frame(input logic [135:0] f, input int len, input int nbits);
    for (int i = len - 1; i >= len - nbits; i--) send_bit(f[i]);
  endtask

  task automatic send_idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  // A strobe with CMD low accompanies start_i; it must not count as the start bit.
  task automatic arm(input logic lng, input logic cc, input logic ci, input logic [5:0] idx);
    start_i       = 1'b1;
    long_rsp_i    = lng;
    check_crc_i   = cc;
    check_index_i = ci;
    cmd_index_i   = idx;
    sd_clk_en_i   = 1'b1;
    sd_cmd_i      = 1'b0;
    @(posedge clk_i);
    #1;
    start_i       = 1'b0;
    sd_clk_en_i   = 1'b0;
    sd_cmd_i      = 1'b1;
    long_rsp_i    = ~lng;
    cmd_index_i   = ~idx;
  endtask

  task automatic wait_done();
    repeat (3) begin
      @(posedge clk_i);
      #1;
    end
    check("done_seen", 128'(sb.size()), 128'd0);
    sb.delete();
  endtask

  task automatic push(input logic [119:0] r, input logic t, input logic c, input logic e,
                      input logic i);
    exp_t x;
    x.rsp  = r;
    x.to   = t;
    x.crc  = c;
    x.endb = e;
    x.idx  = i;
    sb.push_back(x);
  endtask

  logic [135:0] fr;
  logic [119:0] payload;

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_busy", 128'(busy_o), 128'd0);
    check("rst_done", 128'(done_o), 128'd0);
    check("rst_rsp", 128'(rsp_o), 128'd0);
    check("rst_flags", 128'({timeout_err_o, crc_err_o, end_bit_err_o, index_err_o}), 128'd0);
    @(posedge clk_i);
    #1;

    // Good R7; a start_i during WAIT_START with other config must be ignored.
    arm(1'b0, 1'b1, 1'b1, 6'd8);
    @(negedge clk_i);
    check("busy_armed", 128'(busy_o), 128'd1);
    @(posedge clk_i);
    #1;
    start_i    = 1'b1;
    long_rsp_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    send_idle(3);
    fr = short_frame(6'd8, 32'h0000_01AA);
    push({88'h0, 32'h0000_01AA}, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(fr, 48, 48);
    wait_done();
    check("rsp_hold", 128'(rsp_o), 128'h1AA);

    // Received CRC off by one.
    arm(1'b0, 1'b1, 1'b1, 6'd8);
    fr    = short_frame(6'd8, 32'h0000_01AA);
    fr[1] = ~fr[1];
    push({88'h0, 32'h0000_01AA}, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(fr, 48, 48);
    wait_done();

    // End bit low, CRC correct.
    arm(1'b0, 1'b1, 1'b1, 6'd8);
    fr    = short_frame(6'd8, 32'h0000_01AA);
    fr[0] = 1'b0;
    push({88'h0, 32'h0000_01AA}, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(fr, 48, 48);
    wait_done();

    // Index mismatch, then the same with index checking disabled.
    arm(1'b0, 1'b1, 1'b1, 6'd17);
    fr = short_frame(6'd18, 32'h1234_5678);
    push({88'h0, 32'h1234_5678}, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(fr, 48, 48);
    wait_done();
    arm(1'b0, 1'b1, 1'b0, 6'd17);
    push({88'h0, 32'h1234_5678}, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(fr, 48, 48);
    wait_done();

    // Bad CRC ignored when CRC checking is disabled.
    arm(1'b0, 1'b0, 1'b1, 6'd8);
    fr    = short_frame(6'd8, 32'hCAFE_F00D);
    fr[3] = ~fr[3];
    push({88'h0, 32'hCAFE_F00D}, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(fr, 48, 48);
    wait_done();

    // No response: timeout on the 64th strobe.
    arm(1'b0, 1'b1, 1'b1, 6'd8);
    push(120'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    send_idle(64);
    wait_done();

    // Start bit on strobe 63 is still a normal response.
    arm(1'b0, 1'b1, 1'b1, 6'd3);
    send_idle(62);
    fr = short_frame(6'd3, 32'h8000_0001);
    push({88'h0, 32'h8000_0001}, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(fr, 48, 48);
    wait_done();

    // Long R2; index check does not apply to long frames.
    arm(1'b1, 1'b1, 1'b1, 6'd2);
    payload = 120'h0123456789ABCDEF0123456789ABCD;
    fr      = long_frame(payload);
    push(payload, 1'b0, 1'b0, 1'b0, 1'b0);
    send_idle(2);
    send_frame(fr, 136, 136);
    wait_done();

    // Long R2 with corrupted payload bit.
    arm(1'b1, 1'b1, 1'b0, 6'd2);
    fr      = long_frame(payload);
    fr[60]  = ~fr[60];
    push(fr[127:8], 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(fr, 136, 136);
    wait_done();

    // Abort at bit 20, coincident with a strobe; no done_o may follow.
    arm(1'b0, 1'b1, 1'b1, 6'd8);
    fr = short_frame(6'd8, 32'h0000_01AA);
    send_frame(fr, 48, 20);
    abort_i     = 1'b1;
    sd_clk_en_i = 1'b1;
    sd_cmd_i    = fr[27];
    @(posedge clk_i);
    #1;
    abort_i     = 1'b0;
    sd_clk_en_i = 1'b0;
    sd_cmd_i    = 1'b1;
    @(negedge clk_i);
    check("abort_busy", 128'(busy_o), 128'd0);
    @(posedge clk_i);
    #1;
    send_frame(fr, 48, 28);
    repeat (4) begin
      @(posedge clk_i);
      #1;
    end
    arm(1'b0, 1'b1, 1'b1, 6'd55);
    fr = short_frame(6'd55, 32'hDEAD_BEEF);
    push({88'h0, 32'hDEAD_BEEF}, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(fr, 48, 48);
    wait_done();

    // Reset mid-frame after 30 bits (status bits 8..29 already shifted in).
    arm(1'b0, 1'b1, 1'b1, 6'd8);
    fr = short_frame(6'd8, 32'hFFFF_FFFF);
    send_frame(fr, 48, 30);
    @(negedge clk_i);
    check("rsp_partial", 128'(rsp_o), 128'h3F_FFFF);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    @(negedge clk_i);
    check("midrst_busy", 128'(busy_o), 128'd0);
    check("midrst_rsp", 128'(rsp_o), 128'd0);
    check("midrst_flags", 128'({done_o, timeout_err_o, crc_err_o, end_bit_err_o,
                                index_err_o}), 128'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    send_frame(fr, 48, 18);
    repeat (3) @(posedge clk_i);
    check("sb_drained", 128'(sb.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
